// File: rtl/pipe_elastic_latch.sv
// Purpose  : elastic (skid) pipeline latch carrying a WIDTH-bit stage bundle through a
//            DEPTH-entry circular buffer, steered by the 2-bit pipeline_ctrl command.
// Latency  : 1 cycle; a bundle pushed at edge n is on data_out after edge n.
// Backpres.: in_ready drops when full (unless the head pops this cycle) or on hold/flush;
//            bundles are never lost, and a rejected push sets the sticky overflow flag.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous active-low reset
//   ctr        pipeline_ctrl command: 00 run, 01 hold, 10 flush, 11 flush-and-load
//   in_valid   upstream bundle valid
//   in_ready   buffer accepts this cycle (combinational from out_ready via pop)
//   data_in    upstream bundle
//   out_valid  data_out holds a real bundle
//   out_ready  downstream consumes this cycle
//   data_out   head entry, or BUBBLE when empty
//   count      occupied entries
//   overflow   sticky: push attempted in run mode while in_ready was low
module pipe_elastic_latch #(
    parameter int unsigned      WIDTH  = 96,
    // Must be a power of two and at least 2 so the pointers wrap for free.
    parameter int unsigned      DEPTH  = 2,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   ctr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             data_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             data_out,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    localparam logic [1:0] CTR_RUN   = 2'b00;
    localparam logic [1:0] CTR_HOLD  = 2'b01;
    localparam logic [1:0] CTR_FLUSH = 2'b10;
    localparam logic [1:0] CTR_LOAD  = 2'b11;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             overflow_q, overflow_d;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic not_empty;
    logic not_full;
    logic pop;
    logic push;

    assign not_empty = (count_q != '0);
    assign not_full  = (count_q < CW'(DEPTH));

    // Hold suppresses out_valid but leaves data_out untouched, so the
    // downstream stage sees a stable bundle while it is told to wait.
    assign out_valid = not_empty && (ctr != CTR_HOLD);
    assign data_out  = not_empty ? mem_q[rd_ptr_q] : BUBBLE;

    // Only run mode may consume. Flush and flush-and-load discard the
    // contents instead, so a downstream out_ready there is irrelevant.
    assign pop = out_valid && out_ready && (ctr == CTR_RUN);

    // A full buffer still accepts when the head leaves in the same cycle.
    // Flush-and-load always accepts: its slot is guaranteed by the discard.
    always_comb begin
        in_ready = 1'b0;
        case (ctr)
            CTR_RUN:  in_ready = not_full || pop;
            CTR_LOAD: in_ready = 1'b1;
            default:  in_ready = 1'b0;
        endcase
    end

    assign push = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        case (ctr)
            CTR_RUN: begin
                if (push) begin
                    wr_ptr_d = wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                end
                case ({push, pop})
                    2'b10:   count_d = count_q + CW'(1);
                    2'b01:   count_d = count_q - CW'(1);
                    default: count_d = count_q;
                endcase
            end
            CTR_HOLD: begin
                // Everything frozen.
            end
            CTR_FLUSH: begin
                // Collapse the buffer onto the write pointer; entries stay in
                // storage but become unreachable.
                rd_ptr_d = wr_ptr_q;
                count_d  = '0;
            end
            CTR_LOAD: begin
                // The incoming bundle (if any) lands at wr_ptr and becomes
                // the new head, so the read pointer jumps there directly.
                rd_ptr_d = wr_ptr_q;
                if (push) begin
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    count_d  = CW'(1);
                end else begin
                    count_d  = '0;
                end
            end
            default: begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                count_d  = count_q;
            end
        endcase
    end

    assign overflow_d = overflow_q || (in_valid && !in_ready && (ctr == CTR_RUN));

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: an entry is only ever read after it has been
    // written, because count gates data_out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_pipe_elastic_latch.sv
module tb_pipe_elastic_latch;

    localparam int W  = 96;
    localparam int D  = 2;
    localparam int CW = $clog2(D+1);
    localparam logic [W-1:0] BUB = 96'h5A5A0000DEADBEEF00000BAD;

    logic          clk;
    logic          rst;
    logic [1:0]    ctr;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  data_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  data_out;
    logic [CW-1:0] count;
    logic          overflow;

    int tests = 0;
    int fails = 0;

    // Reference model: queue of stored bundles (front = head) plus sticky flag.
    logic [W-1:0] q[$];
    logic         m_ovf;

    pipe_elastic_latch #(
        .WIDTH  (W),
        .DEPTH  (D),
        .BUBBLE (BUB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ctr       (ctr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .count     (count),
        .overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    // One clock cycle: drive inputs, compare all outputs with the model just
    // before the edge, advance the model, then cross the edge.
    task automatic cycle(input logic [1:0] c, input logic iv, input logic [W-1:0] d, input logic ordy);
        int           n;
        logic         pop;
        logic         ir;
        logic         push;
        logic [W-1:0] head;
        ctr       = c;
        in_valid  = iv;
        data_in   = d;
        out_ready = ordy;
        #1;
        n    = q.size();
        head = (n != 0) ? q[0] : BUB;
        pop  = (n != 0) && (c == 2'b00) && ordy;
        ir   = (c == 2'b11) || ((c == 2'b00) && ((n < D) || pop));
        push = iv && ir;
        check("count",     W'(count),     W'(n));
        check("out_valid", W'(out_valid), W'((n != 0) && (c != 2'b01)));
        check("data_out",  data_out,      head);
        check("in_ready",  W'(in_ready),  W'(ir));
        check("overflow",  W'(overflow),  W'(m_ovf));
        if ((c == 2'b00) && iv && !ir) m_ovf = 1'b1;
        case (c)
            2'b00: begin
                if (pop)  void'(q.pop_front());
                if (push) q.push_back(d);
            end
            2'b10: q.delete();
            2'b11: begin
                q.delete();
                if (iv) q.push_back(d);
            end
            default: ;
        endcase
        @(posedge clk);
        #1;
    endtask

    initial begin
        int r;
        rst       = 1'b1;
        ctr       = 2'b00;
        in_valid  = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;
        m_ovf     = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("rst_count",     W'(count),     W'(0));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_data_out",  data_out,      BUB);
        check("rst_overflow",  W'(overflow),  W'(0));
        check("rst_in_ready",  W'(in_ready),  W'(1));
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        // Fill to full, third push is rejected and flagged.
        cycle(2'b00, 1'b1, 96'hA1, 1'b0);
        cycle(2'b00, 1'b1, 96'hA2, 1'b0);
        cycle(2'b00, 1'b1, 96'hA3, 1'b0);
        check("full_count",    W'(count),    W'(2));
        check("full_overflow", W'(overflow), W'(1));
        check("full_head",     data_out,     96'hA1);

        // Full: simultaneous push and pop, then drain.
        cycle(2'b00, 1'b1, 96'hB3, 1'b1);
        check("pp_count", W'(count), W'(2));
        check("pp_head",  data_out,  96'hA2);
        cycle(2'b00, 1'b0, '0, 1'b1);
        check("drain_head", data_out, 96'hB3);
        cycle(2'b00, 1'b0, '0, 1'b1);
        check("drain_empty", data_out, BUB);

        // Hold for three cycles with both sides eager.
        cycle(2'b00, 1'b1, 96'hA1, 1'b0);
        cycle(2'b00, 1'b1, 96'hA2, 1'b0);
        for (int i = 0; i < 3; i++) cycle(2'b01, 1'b1, 96'hEE, 1'b1);
        check("hold_count", W'(count), W'(2));
        check("hold_head",  data_out,  96'hA1);
        cycle(2'b00, 1'b0, '0, 1'b1);
        check("resume_head", data_out, 96'hA2);
        cycle(2'b00, 1'b1, rnd(), 1'b0);

        // Flush drops stored entries and the incoming bundle.
        cycle(2'b10, 1'b1, 96'hC0, 1'b1);
        check("flush_count", W'(count), W'(0));
        check("flush_data",  data_out,  BUB);
        cycle(2'b00, 1'b0, '0, 1'b0);

        // Flush-and-load with a full buffer, then in-order push/pop pairs.
        cycle(2'b00, 1'b1, rnd(), 1'b0);
        cycle(2'b00, 1'b1, rnd(), 1'b0);
        cycle(2'b11, 1'b1, 96'hD5, 1'b0);
        check("load_count", W'(count),     W'(1));
        check("load_data",  data_out,      96'hD5);
        check("load_valid", W'(out_valid), W'(1));
        for (int i = 0; i < 10; i++) cycle(2'b00, 1'b1, rnd(), 1'b1);

        // Randomised mix of commands and handshakes.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                6:       cycle(2'b01, 1'($urandom), rnd(), 1'($urandom));
                7:       cycle(2'b10, 1'($urandom), rnd(), 1'($urandom));
                8:       cycle(2'b11, 1'($urandom), rnd(), 1'($urandom));
                default: cycle(2'b00, 1'($urandom), rnd(), 1'($urandom));
            endcase
        end

        // Asynchronous reset between edges with a full buffer.
        cycle(2'b10, 1'b0, '0, 1'b0);
        cycle(2'b00, 1'b1, rnd(), 1'b0);
        cycle(2'b00, 1'b1, rnd(), 1'b0);
        cycle(2'b00, 1'b1, rnd(), 1'b0);
        rst = 1'b0;
        #1;
        check("arst_count",     W'(count),     W'(0));
        check("arst_out_valid", W'(out_valid), W'(0));
        check("arst_data_out",  data_out,      BUB);
        check("arst_overflow",  W'(overflow),  W'(0));
        #1 rst = 1'b1;
        q.delete();
        m_ovf = 1'b0;
        for (int i = 0; i < 20; i++) cycle(2'b00, 1'($urandom), rnd(), 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_elastic_latch.md
Name: pipe_elastic_latch

Overview:
- Parametrised successor to the fixed-width stall/flush pipeline latch between pipeline stages.
- Carries a WIDTH-bit stage bundle through a DEPTH-entry elastic (skid) buffer with valid/ready handshake on both sides.
- Keeps the existing 2-bit pipeline_ctrl command interface and adds flush-and-load.
- Lets a slow downstream stage (multi-cycle EX, cache-miss MEM) back-pressure without losing in-flight bundles.

Parameters:
WIDTH, 96, bits per stage bundle
DEPTH, 2, buffer entries; power of two, >=2
BUBBLE, 0, WIDTH-bit value driven on data_out when empty or flushed

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
ctr  in  2  command from pipeline_ctrl: 00 run, 01 hold, 10 flush, 11 flush-and-load
in_valid  in  1  upstream bundle valid
in_ready  out  1  buffer can accept this cycle
data_in  in  WIDTH  upstream bundle
out_valid  out  1  data_out holds a real bundle
out_ready  in  1  downstream consumes this cycle
data_out  out  WIDTH  head entry, or BUBBLE when empty
count  out  clog2(DEPTH+1)  occupied entries
overflow  out  1  sticky: push attempted while in_ready=0

Behaviour:
- Reset (rst=0, async):
  - wr_ptr=rd_ptr=0, count=0, out_valid=0.
  - data_out=BUBBLE, overflow=0.
  - Storage contents don't care.
  - Release is taken at the next rising edge.
- Storage is a circular buffer.
  - data_out comes from entry[rd_ptr] via a mux on registered state only.
  - Latency 1: a push at edge n is visible on data_out after edge n.
- out_valid = (count!=0) and ctr!=01.
- data_out = entry[rd_ptr] when count!=0, else BUBBLE.
  - During hold, data_out stays stable and out_valid=0.
- pop = out_valid & out_ready & ctr==00.
- in_ready = ctr==00 & (count<DEPTH | pop). This is a combinational path from out_ready; downstream must not loop it back.
- push = in_valid & in_ready.
- Pointers wrap modulo DEPTH.
  - count += push - pop.
  - Simultaneous push and pop leaves count unchanged, including when full and when count=1.
- ctr=01 hold:
  - No push, no pop, in_ready=0.
  - All state frozen.
- ctr=10 flush:
  - At the edge, count=0 and rd_ptr=wr_ptr.
  - Input is dropped and in_ready=0.
  - Next cycle data_out=BUBBLE and out_valid=0.
- ctr=11 flush-and-load:
  - Stored entries are discarded.
  - If in_valid, data_in becomes the sole entry (count=1); otherwise count=0.
  - in_ready=1 this cycle.
  - Used for branch/interrupt redirect.
- overflow is set when in_valid & ~in_ready & ctr==00. It clears only on reset.
- ctr changes mid-transfer take effect on the same cycle's ready/valid; no partial entries are possible.
- count never exceeds DEPTH and never underflows. Pop on empty is impossible because out_valid=0.

Test Plan:
- Reset mid-stream, with count=2 and rst pulsed low between edges -> immediately count=0, out_valid=0, data_out=BUBBLE, overflow=0.
- DEPTH=2, out_ready=0, push 0xA1, 0xA2, then 0xA3 -> count=2, in_ready=0 on the third cycle, overflow=1, data_out=0xA1.
- Full buffer, in_valid=1 with 0xB3, out_ready=1 -> same-cycle push and pop; count stays 2, data_out sequence 0xA1, 0xA2, 0xB3.
- count=2, ctr=01 for 3 cycles while in_valid=out_ready=1 -> no change; data_out=0xA1 stable, out_valid=0, in_ready=0. Then ctr=00 resumes with 0xA1 popped first.
- count=2, ctr=10 with in_valid=1 and data_in=0xC0 -> next cycle count=0, data_out=BUBBLE. 0xC0 is never emitted.
- count=2, ctr=11 with data_in=0xD5 -> next cycle count=1, data_out=0xD5, out_valid=1. Pointer wrap is checked over 10 further push/pop pairs with an in-order scoreboard.
